// File: rtl/mining_pkg.sv
// Shared types, constants and helpers for the nonce sweep scheduler family.
package mining_pkg;

    localparam int NONCE_MSB = 415;
    localparam int MSG_W     = 1024;

    typedef logic [255:0]     digest_t;
    typedef logic [MSG_W-1:0] msg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_CHECK,
        ST_REPORT,
        ST_DRAIN
    } state_t;

    // The header stores the nonce little-endian, while the message is indexed big-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] n);
        return {n[7:0], n[15:8], n[23:16], n[31:24]};
    endfunction

endpackage

// File: rtl/nonce_splice.sv
// Inserts a byte-swapped nonce into a padded header message; purely combinational.
module nonce_splice
    import mining_pkg::*;
#(
    parameter int NONCE_MSB = mining_pkg::NONCE_MSB
) (
    input  logic [MSG_W-1:0] msg_i,
    input  logic [31:0]      nonce_i,
    output logic [MSG_W-1:0] msg_o
);

    always_comb begin
        msg_o                  = msg_i;
        msg_o[NONCE_MSB -: 32] = bswap32(nonce_i);
    end

endmodule

// File: rtl/nonce_sweep_scheduler.sv
// Drives one double-SHA-256 core across an inclusive nonce range and reports
// the first digest at or below the target, range exhaustion, or a core timeout.
module nonce_sweep_scheduler
    import mining_pkg::*;
#(
    parameter int NONCE_MSB = mining_pkg::NONCE_MSB,
    parameter int WATCHDOG  = 4096,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [1023:0]     job_msg,
    input  logic [255:0]      job_target,
    input  logic [31:0]       nonce_start,
    input  logic [31:0]       nonce_end,
    input  logic              abort,
    output logic              core_start,
    output logic [1023:0]     core_msg,
    input  logic              core_done,
    input  logic [255:0]      core_sha,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_found,
    output logic              res_timeout,
    output logic [31:0]       res_nonce,
    output logic [255:0]      res_hash,
    output logic              busy,
    output logic [CNT_W-1:0]  hash_count
);

    localparam int               WD_W    = $clog2(WATCHDOG + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WATCHDOG - 1);

    state_t            state_q,   state_d;
    msg_t              msg_q,     msg_d;
    digest_t           target_q,  target_d;
    digest_t           digest_q,  digest_d;
    logic [31:0]       nonce_q,   nonce_d;
    logic [31:0]       end_q,     end_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [WD_W-1:0]   wd_q,      wd_d;
    logic              found_q,   found_d;
    logic              timeout_q, timeout_d;

    logic              job_accept;
    logic              wd_expired;
    logic              hit;

    assign job_accept = job_valid && job_ready;
    assign wd_expired = (wd_q == WD_LAST);
    assign hit        = (digest_q <= target_q);

    always_comb begin
        // NOTE: every _d takes its hold value first, so no branch of the case
        // below can leave one unassigned and infer a latch.
        state_d   = state_q;
        msg_d     = msg_q;
        target_d  = target_q;
        digest_d  = digest_q;
        nonce_d   = nonce_q;
        end_d     = end_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        found_d   = found_q;
        timeout_d = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (job_accept) begin
                    msg_d     = job_msg;
                    target_d  = job_target;
                    nonce_d   = nonce_start;
                    end_d     = nonce_end;
                    digest_d  = '0;
                    cnt_d     = '0;
                    found_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = (nonce_start > nonce_end) ? ST_REPORT : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wd_d    = '0;
                state_d = abort ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (abort) begin
                    // A digest arriving with the abort is already consumed; nothing left to drain.
                    state_d = core_done ? ST_IDLE : ST_DRAIN;
                    wd_d    = wd_q + 1'b1;
                end else if (core_done) begin
                    digest_d = core_sha;
                    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    state_d  = ST_CHECK;
                end else if (wd_expired) begin
                    digest_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_REPORT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (hit) begin
                    found_d = 1'b1;
                    state_d = ST_REPORT;
                end else if (nonce_q == end_q) begin
                    state_d = ST_REPORT;
                end else begin
                    nonce_d = nonce_q + 32'd1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (core_done || wd_expired) begin
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide message and digest registers are reset as well, because
            // the outputs they feed must read zero while in reset.
            state_q   <= ST_IDLE;
            msg_q     <= '0;
            target_q  <= '0;
            digest_q  <= '0;
            nonce_q   <= '0;
            end_q     <= '0;
            cnt_q     <= '0;
            wd_q      <= '0;
            found_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values
            // regardless of statement order.
            state_q   <= state_d;
            msg_q     <= msg_d;
            target_q  <= target_d;
            digest_q  <= digest_d;
            nonce_q   <= nonce_d;
            end_q     <= end_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            found_q   <= found_d;
            timeout_q <= timeout_d;
        end
    end

    // core_msg only changes when nonce_q does (CHECK), so it is stable across WAIT.
    nonce_splice #(
        .NONCE_MSB (NONCE_MSB)
    ) u_splice (
        .msg_i   (msg_q),
        .nonce_i (nonce_q),
        .msg_o   (core_msg)
    );

    assign job_ready   = (state_q == ST_IDLE) && !rst;
    assign busy        = (state_q != ST_IDLE);
    assign core_start  = (state_q == ST_LAUNCH);
    assign res_valid   = (state_q == ST_REPORT);
    assign res_found   = found_q;
    assign res_timeout = timeout_q;
    assign res_nonce   = nonce_q;
    assign res_hash    = digest_q;
    assign hash_count  = cnt_q;

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Directed bench for nonce_sweep_scheduler with a behavioural double-SHA-256 core.
module tb_nonce_sweep_scheduler;

    localparam int WD       = 16;
    localparam int CORE_LAT = 5;

    localparam logic [2047:0] SHA_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] SHA_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Genesis header with junk in the nonce field, which the scheduler must overwrite.
    localparam logic [1023:0] GEN_MSG = {
        32'h01000000,
        256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49,
        32'hffff001d,
        32'hdeadbeef,
        8'h80, 312'h0, 64'h280
    };
    localparam logic [255:0] GEN_TGT  = {32'h0, 16'hffff, 208'h0};
    localparam logic [255:0] GEN_HASH = 256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

    logic           clk;
    logic           rst;
    logic           job_valid;
    logic           job_ready;
    logic [1023:0]  job_msg;
    logic [255:0]   job_target;
    logic [31:0]    nonce_start;
    logic [31:0]    nonce_end;
    logic           abort;
    logic           core_start;
    logic [1023:0]  core_msg;
    logic           core_done;
    logic [255:0]   core_sha;
    logic           res_valid;
    logic           res_ready;
    logic           res_found;
    logic           res_timeout;
    logic [31:0]    res_nonce;
    logic [255:0]   res_hash;
    logic           busy;
    logic [31:0]    hash_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int job_id = 0;
    int start_cnt = 0;
    bit core_hang = 1'b0;

    nonce_sweep_scheduler #(
        .WATCHDOG (WD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_msg     (job_msg),
        .job_target  (job_target),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .abort       (abort),
        .core_start  (core_start),
        .core_msg    (core_msg),
        .core_done   (core_done),
        .core_sha    (core_sha),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_found   (res_found),
        .res_timeout (res_timeout),
        .res_nonce   (res_nonce),
        .res_hash    (res_hash),
        .busy        (busy),
        .hash_count  (hash_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
            t1 = h + s1 + ((e & f) ^ (~e & g)) + SHA_K[2047-32*i -: 32] + w[i];
            s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Double SHA-256 of a two-block message, returned byte-reversed (display order).
    function automatic logic [255:0] double_sha(input logic [1023:0] m);
        logic [255:0] h1, h2, r;
        h1 = sha_compress(SHA_IV, m[1023:512]);
        h1 = sha_compress(h1, m[511:0]);
        h2 = sha_compress(SHA_IV, {h1, 1'b1, 191'h0, 64'd256});
        for (int i = 0; i < 32; i++) r[8*i +: 8] = h2[255-8*i -: 8];
        return r;
    endfunction

    function automatic logic [255:0] ref_digest(input logic [1023:0] m, input logic [31:0] n);
        logic [1023:0] s;
        s = m;
        s[415 -: 32] = {n[7:0], n[15:8], n[23:16], n[31:24]};
        return double_sha(s);
    endfunction

    // Behavioural core: fixed latency, optionally never completes.
    initial begin
        int done_job;
        int done_cyc;
        logic [1023:0] cap;
        logic [255:0]  dig;
        done_job  = -1;
        done_cyc  = 0;
        core_done = 1'b0;
        core_sha  = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                start_cnt++;
                if (done_job == job_id) check("cadence", 256'(cyc - done_cyc), 2);
                if (!core_hang) begin
                    cap = core_msg;
                    dig = double_sha(cap);
                    repeat (CORE_LAT) @(negedge clk);
                    check("msg_stable", 256'(core_msg == cap), 1);
                    done_job  = job_id;
                    done_cyc  = cyc;
                    core_done = 1'b1;
                    core_sha  = dig;
                    @(negedge clk);
                    core_done = 1'b0;
                end
            end
        end
    end

    int start_base;

    task automatic submit(input logic [1023:0] m, input logic [255:0] t,
                          input logic [31:0] s, input logic [31:0] e);
        job_msg     = m;
        job_target  = t;
        nonce_start = s;
        nonce_end   = e;
        job_id++;
        start_base  = start_cnt;
        job_valid   = 1'b1;
        @(negedge clk);
        job_valid   = 1'b0;
    endtask

    task automatic wait_res(input int budget);
        int n;
        n = 0;
        while (!res_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("res_valid_reached", 256'(res_valid), 1);
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_drop", 256'(res_valid), 0);
        check("job_ready_after", 256'(job_ready), 1);
    endtask

    initial begin
        int n;
        bit seen;
        rst = 1'b1; job_valid = 1'b0; job_msg = '0; job_target = '0;
        nonce_start = '0; nonce_end = '0; abort = 1'b0; res_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_job_ready", 256'(job_ready), 0);
        check("rst_busy", 256'(busy), 0);
        check("rst_res_valid", 256'(res_valid), 0);
        check("rst_core_start", 256'(core_start), 0);
        check("rst_core_msg_zero", 256'(core_msg == '0), 1);
        check("rst_hash_count", 256'(hash_count), 0);
        check("rst_res_hash", res_hash, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_job_ready", 256'(job_ready), 1);

        // Genesis block: hit on the fourth nonce.
        submit(GEN_MSG, GEN_TGT, 32'h7c2bac1a, 32'h7c2bac20);
        wait_res(300);
        check("gen_found", 256'(res_found), 1);
        check("gen_timeout", 256'(res_timeout), 0);
        check("gen_nonce", 256'(res_nonce), 256'h7c2bac1d);
        check("gen_hash", res_hash, GEN_HASH);
        check("gen_count", 256'(hash_count), 4);
        check("gen_starts", 256'(start_cnt - start_base), 4);
        repeat (3) @(negedge clk);
        check("gen_hold_valid", 256'(res_valid), 1);
        check("gen_hold_nonce", 256'(res_nonce), 256'h7c2bac1d);
        release_res();

        // Unreachable target: sweep 0..3 to exhaustion.
        submit(GEN_MSG, 256'h0, 32'd0, 32'd3);
        wait_res(300);
        check("exh_found", 256'(res_found), 0);
        check("exh_nonce", 256'(res_nonce), 3);
        check("exh_count", 256'(hash_count), 4);
        check("exh_starts", 256'(start_cnt - start_base), 4);
        check("exh_hash", res_hash, ref_digest(GEN_MSG, 32'd3));
        release_res();

        // Empty range reports immediately without launching.
        submit(GEN_MSG, GEN_TGT, 32'd5, 32'd4);
        check("empty_valid", 256'(res_valid), 1);
        check("empty_found", 256'(res_found), 0);
        check("empty_nonce", 256'(res_nonce), 5);
        check("empty_hash", res_hash, 0);
        check("empty_count", 256'(hash_count), 0);
        repeat (2) @(negedge clk);
        check("empty_starts", 256'(start_cnt - start_base), 0);
        release_res();

        // Core never completes: watchdog ends WAIT after WD cycles.
        core_hang = 1'b1;
        submit(GEN_MSG, GEN_TGT, 32'd10, 32'd20);
        check("hang_launch", 256'(core_start), 1);
        n = 0;
        while (!res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("hang_cycles", 256'(n), WD + 1);
        check("hang_timeout", 256'(res_timeout), 1);
        check("hang_found", 256'(res_found), 0);
        check("hang_nonce", 256'(res_nonce), 10);
        check("hang_count", 256'(hash_count), 0);
        release_res();
        core_hang = 1'b0;

        // Top of the nonce space terminates by equality, not wrap.
        submit(GEN_MSG, 256'h0, 32'hfffffffe, 32'hffffffff);
        wait_res(200);
        check("wrap_nonce", 256'(res_nonce), 256'hffffffff);
        check("wrap_count", 256'(hash_count), 2);
        check("wrap_starts", 256'(start_cnt - start_base), 2);
        check("wrap_found", 256'(res_found), 0);
        release_res();

        // Abort in WAIT drains the in-flight hash and returns silently.
        submit(GEN_MSG, 256'h0, 32'd0, 32'd100);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("drain_busy", 256'(busy), 1);
        seen = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
            if (res_valid) seen = 1'b1;
        end
        repeat (3) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("drain_exit", 256'(busy), 0);
        check("drain_no_result", 256'(seen), 0);
        check("drain_job_ready", 256'(job_ready), 1);
        check("drain_starts", 256'(start_cnt - start_base), 1);

        // Reset mid-WAIT clears everything on the next cycle.
        core_hang = 1'b1;
        submit(GEN_MSG, 256'h0, 32'd7, 32'd9);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 256'(busy), 0);
        check("mid_rst_job_ready", 256'(job_ready), 0);
        check("mid_rst_core_start", 256'(core_start), 0);
        check("mid_rst_core_msg_zero", 256'(core_msg == '0), 1);
        check("mid_rst_res_nonce", 256'(res_nonce), 0);
        check("mid_rst_hash_count", 256'(hash_count), 0);
        check("mid_rst_res_valid", 256'(res_valid), 0);
        rst = 1'b0;
        core_hang = 1'b0;
        @(negedge clk);
        check("post_rst_job_ready", 256'(job_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no end of run, expected end within 100000 cycles");
        $fatal(1, "bench time limit exceeded");
    end

endmodule

// File: doc/nonce_sweep_scheduler.md
Name: nonce_sweep_scheduler

Overview:
- Sequences the double-SHA-256 hash core across a nonce range for one mining job.
- Accepts a 1024-bit padded header job, a target and an inclusive nonce range.
- For each nonce, splices the nonce into the message, launches the core and waits for completion.
- Compares each digest against the target and reports the first hit, range exhaustion or a core timeout.
- Sits between the job/host interface and a single hash core instance.

Parameters:
- NONCE_MSB, 415: message bit index of the nonce field's MSB (header bytes 76..79).
- WATCHDOG, 4096: maximum cycles to wait for core_done before declaring a timeout.
- CNT_W, 32: width of hash_count.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  scheduler can accept a job (IDLE only)
- job_msg  in  1024  padded two-block header; the nonce field content is ignored
- job_target  in  256  threshold, same byte order as core_sha
- nonce_start  in  32  first nonce, inclusive
- nonce_end  in  32  last nonce, inclusive
- abort  in  1  cancel the current sweep
- core_start  out  1  one-cycle launch pulse to the core
- core_msg  out  1024  message presented to the core; stable from core_start until core_done
- core_done  in  1  one-cycle completion pulse from the core
- core_sha  in  256  core digest, valid while core_done=1
- res_valid  out  1  result available; held until res_ready
- res_ready  in  1  result consumed
- res_found  out  1  1 = hit, 0 = range exhausted or empty range
- res_timeout  out  1  core failed to complete within WATCHDOG cycles
- res_nonce  out  32  hit nonce, or last nonce tried
- res_hash  out  256  digest for res_nonce
- busy  out  1  not in IDLE
- hash_count  out  CNT_W  hashes completed for the current job

Behaviour:
- Reset: all outputs 0, including res_*, core_msg and hash_count. State=IDLE. job_ready=0 during reset and 1 in IDLE after reset.
- Splice: core_msg = job_msg with bits [NONCE_MSB -: 32] replaced by byte-swapped nonce ({n[7:0],n[15:8],n[23:16],n[31:24]}).
- IDLE: on job_valid&&job_ready, latch job_msg, target and range; clear hash_count. If nonce_start>nonce_end (unsigned), go to REPORT with found=0, nonce=nonce_start, hash=0. Otherwise nonce=nonce_start and go to LAUNCH.
- LAUNCH (1 cycle): drive core_msg, pulse core_start, clear the watchdog counter, go to WAIT.
- WAIT: watchdog counter increments each cycle.
  - On core_done: capture core_sha, hash_count+1, go to CHECK.
  - When the counter reaches WATCHDOG with no core_done: go to REPORT with timeout=1, found=0.
- CHECK (1 cycle): hit when core_sha <= target, as 256-bit unsigned.
  - Hit: go to REPORT with found=1.
  - Miss and nonce==nonce_end: go to REPORT with found=0.
  - Otherwise: nonce+1, go to LAUNCH.
  - nonce_end=0xFFFFFFFF therefore terminates by equality, never by wrap.
- Launch cadence: core_done to the next core_start is exactly 2 cycles (CHECK, LAUNCH).
- REPORT: res_valid=1 with all res_* stable. Leave to IDLE on res_ready; res_valid drops the following cycle. Results are never overwritten.
- Abort:
  - In LAUNCH or WAIT: go to DRAIN, which waits for core_done or watchdog expiry, discards the digest, then returns to IDLE with no result.
  - In CHECK: go directly to IDLE.
  - In IDLE or REPORT: ignored.
- Simultaneous events:
  - abort with core_done in WAIT: abort wins and the digest is discarded.
  - job_valid during busy: not accepted.
- rst mid-sweep: immediate return to IDLE. The core is expected to be reset by the same rst.
- hash_count saturates at all-ones.

Decomposition:
- Shared package mining_pkg: state enum, NONCE_MSB, 256-bit target/digest typedef, byte-swap function.
- One sub-module, nonce_splice: combinational insertion and byte-swap. It is reused by future multi-core schedulers.

Test Plan:
- Genesis header (job nonce field zeroed), target 0x00000000FFFF0000…0, range 0x7C2BAC1A..0x7C2BAC20, behavioural core → res_found=1, res_nonce=0x7C2BAC1D, res_hash=0x000000000019d668…8ce26f, hash_count=4.
- Same job, target 0, range 0..3 → res_found=0, res_nonce=3, hash_count=4; core_start pulses exactly 4 times, 2 cycles after each core_done.
- nonce_start=5, nonce_end=4 → res_valid within 2 cycles of accept, res_found=0, hash_count=0, no core_start.
- Core model never asserts done, WATCHDOG=16 → res_timeout=1 exactly 16 cycles into WAIT, res_found=0.
- Range 0xFFFFFFFE..0xFFFFFFFF, target 0 → exactly 2 hashes, res_nonce=0xFFFFFFFF, no wrap to 0.
- abort in WAIT, then res_ready held low → DRAIN until core_done, back to IDLE, res_valid never asserts, job_ready=1 afterwards. rst asserted in WAIT → all outputs 0 on the next cycle.
